// File: rtl/d_cache_pkg.sv
// Shared dcache definitions: opcodes, access-size encodings and line geometry.
// Used by the request splitter and the return-path merger.
package d_cache_pkg;

  localparam logic [2:0] NOOP  = 3'd0;
  localparam logic [2:0] LD    = 3'd1;
  localparam logic [2:0] ST    = 3'd2;
  localparam logic [2:0] RD    = 3'd3;
  localparam logic [2:0] WR    = 3'd4;
  localparam logic [2:0] INV   = 3'd5;
  localparam logic [2:0] UPD   = 3'd6;
  localparam logic [2:0] WR_LD = 3'd7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_RSVD = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  localparam int CL_BYTES = 16;
  localparam int OFF_W    = 4;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } split_state_e;

  function automatic logic [4:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 5'd1;
      SZ_HALF: return 5'd2;
      SZ_WORD: return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/d_split_lane.sv
// One bank's request register: captures a placed request, then holds it
// stable with valid high until the bank handshakes.
module d_split_lane #(
  parameter int CL_SIZE = 128,
  parameter int TAG_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 need,
  input  logic                 ready,
  input  logic [31:0]          addr_in,
  input  logic [CL_SIZE-1:0]   data_in,
  input  logic [CL_SIZE/8-1:0] mask_in,
  input  logic [1:0]           size_in,
  input  logic [2:0]           op_in,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 valid,
  output logic [31:0]          addr,
  output logic [CL_SIZE-1:0]   data,
  output logic [CL_SIZE/8-1:0] mask,
  output logic [1:0]           size,
  output logic [2:0]           op,
  output logic [TAG_W-1:0]     tag,
  output logic                 busy_next
);

  logic                 valid_q, valid_d;
  logic [31:0]          addr_q, addr_d;
  logic [CL_SIZE-1:0]   data_q, data_d;
  logic [CL_SIZE/8-1:0] mask_q, mask_d;
  logic [1:0]           size_q, size_d;
  logic [2:0]           op_q, op_d;
  logic [TAG_W-1:0]     tag_q, tag_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    size_d  = size_q;
    op_d    = op_q;
    tag_d   = tag_q;
    if (load) begin
      valid_d = need;
      addr_d  = addr_in;
      data_d  = data_in;
      mask_d  = mask_in;
      size_d  = size_in;
      op_d    = op_in;
      tag_d   = tag_in;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      size_q  <= '0;
      op_q    <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      size_q  <= size_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  // Independent of load so the top FSM can use it without a combinational loop.
  assign busy_next = valid_q & ~ready;

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign mask  = mask_q;
  assign size  = size_q;
  assign op    = op_q;
  assign tag   = tag_q;

endmodule

// File: rtl/d_split.sv
// LD/ST splitter: places one request across the even/odd dcache banks,
// computes return-path steering and holds until every needed bank accepts.
module d_split
  import d_cache_pkg::*;
#(
  parameter int CL_SIZE      = 128,
  parameter int OOO_TAG_SIZE = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [31:0]             addr_in,
  input  logic [31:0]             data_in,
  input  logic [1:0]              size_in,
  input  logic [2:0]              operation_in,
  input  logic [OOO_TAG_SIZE-1:0] ooo_tag_in,
  output logic                    valid_e,
  output logic                    valid_o,
  input  logic                    ready_e,
  input  logic                    ready_o,
  output logic [31:0]             addr_e,
  output logic [31:0]             addr_o,
  output logic [CL_SIZE-1:0]      data_e,
  output logic [CL_SIZE-1:0]      data_o,
  output logic [CL_SIZE/8-1:0]    mask_e,
  output logic [CL_SIZE/8-1:0]    mask_o,
  output logic [1:0]              size_e,
  output logic [1:0]              size_o,
  output logic [2:0]              operation_e,
  output logic [2:0]              operation_o,
  output logic [OOO_TAG_SIZE-1:0] ooo_tag_e,
  output logic [OOO_TAG_SIZE-1:0] ooo_tag_o,
  output logic                    use_e_as_0,
  output logic                    need_p1,
  output logic                    err_out
);

  localparam int CLB = CL_SIZE / 8;
  localparam int WIN = 2 * CL_SIZE;
  localparam logic [2*CLB-1:0] MASK_ONE = 1;

  split_state_e state_q, state_d;
  logic err_q, err_d, use_e_as_0_q, use_e_as_0_d, need_p1_q, need_p1_d;
  logic load, issue;

  logic [OFF_W-1:0]   off;
  logic [4:0]         nb, span;
  logic               need_p1_w, is_ld, is_st, line0_odd, need_e, need_o;
  logic [WIN-1:0]     placed;
  logic [2*CLB-1:0]   mask_win;
  logic [31:0]        addr_l1, e_addr, o_addr;
  logic [CL_SIZE-1:0] l0_data, l1_data, e_data, o_data;
  logic [CLB-1:0]     e_mask, o_mask;
  logic               busy_e_next, busy_o_next;

  // Place the access in a two-line window; the lower line is the one addr_in hits.
  always_comb begin
    off       = addr_in[OFF_W-1:0];
    nb        = size_to_bytes(size_in);
    span      = {1'b0, off} + nb;
    need_p1_w = span > 5'(CLB);
    is_ld     = (operation_in == LD);
    is_st     = (operation_in == ST);
    line0_odd = addr_in[4];
    addr_l1   = {addr_in[31:4] + 28'd1, 4'b0000};
    placed    = {{(WIN-32){1'b0}}, data_in} << {off, 3'b000};
    mask_win  = ((MASK_ONE << nb) - MASK_ONE) << off;
    l0_data   = is_ld ? '0 : placed[CL_SIZE-1:0];
    l1_data   = is_ld ? '0 : placed[WIN-1:CL_SIZE];
    e_addr    = line0_odd ? addr_l1 : addr_in;
    o_addr    = line0_odd ? addr_in : addr_l1;
    e_data    = line0_odd ? l1_data : l0_data;
    o_data    = line0_odd ? l0_data : l1_data;
    e_mask    = line0_odd ? mask_win[2*CLB-1:CLB] : mask_win[CLB-1:0];
    o_mask    = line0_odd ? mask_win[CLB-1:0] : mask_win[2*CLB-1:CLB];
    need_e    = ~line0_odd | need_p1_w;
    need_o    = line0_odd | need_p1_w;
  end

  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    load         = 1'b0;
    issue        = 1'b0;
    use_e_as_0_d = use_e_as_0_q;
    need_p1_d    = need_p1_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          load         = 1'b1;
          use_e_as_0_d = ~addr_in[4];
          need_p1_d    = need_p1_w;
          if (size_in == SZ_RSVD) begin
            err_d = 1'b1;
          end else if (is_ld || is_st) begin
            issue   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!busy_e_next && !busy_o_next) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      err_q        <= 1'b0;
      use_e_as_0_q <= 1'b0;
      need_p1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      use_e_as_0_q <= use_e_as_0_d;
      need_p1_q    <= need_p1_d;
    end
  end

  d_split_lane #(.CL_SIZE(CL_SIZE), .TAG_W(OOO_TAG_SIZE)) u_lane_e (
    .clk(clk), .rst_n(rst), .load(load), .need(issue & need_e), .ready(ready_e),
    .addr_in(e_addr), .data_in(e_data), .mask_in(e_mask), .size_in(size_in),
    .op_in(operation_in), .tag_in(ooo_tag_in),
    .valid(valid_e), .addr(addr_e), .data(data_e), .mask(mask_e), .size(size_e),
    .op(operation_e), .tag(ooo_tag_e), .busy_next(busy_e_next)
  );

  d_split_lane #(.CL_SIZE(CL_SIZE), .TAG_W(OOO_TAG_SIZE)) u_lane_o (
    .clk(clk), .rst_n(rst), .load(load), .need(issue & need_o), .ready(ready_o),
    .addr_in(o_addr), .data_in(o_data), .mask_in(o_mask), .size_in(size_in),
    .op_in(operation_in), .tag_in(ooo_tag_in),
    .valid(valid_o), .addr(addr_o), .data(data_o), .mask(mask_o), .size(size_o),
    .op(operation_o), .tag(ooo_tag_o), .busy_next(busy_o_next)
  );

  assign ready_out  = (state_q == S_IDLE);
  assign err_out    = err_q;
  assign use_e_as_0 = use_e_as_0_q;
  assign need_p1    = need_p1_q;

endmodule
